sync_fifo_ctrl: RTL and testbench

//  Single-clock, parametrised FIFO for buffering within the 90 MHz master domain.

---
 rtl/sync_fifo_ctrl_pkg.sv | 31 +++
 rtl/sync_fifo_ctrl_if.sv | 53 +++++
 rtl/sync_fifo_ctrl_dp_ram.sv | 28 ++
 rtl/sync_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants and helpers for the single-clock FIFO controller and its
// dual-port storage. The defaults here are also the ones used by the dual-clock FIFO.
package sync_fifo_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    // Which side of the FIFO moves on a given edge, built as {write, read}.
    typedef enum logic [1:0] {
        ACC_NONE  = 2'b00,
        ACC_READ  = 2'b01,
        ACC_WRITE = 2'b10,
        ACC_BOTH  = 2'b11
    } access_e;

    // Ceiling log2 that is usable in parameter expressions.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width_f(input int depth);
        return clog2_f(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Bus between a same-clock producer/consumer and the FIFO controller.
// The master side drives data and requests; the slave side is the FIFO.
interface sync_fifo_ctrl_if
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = clog2_f(DEFAULT_FIFO_DEPTH)
);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  w_en;
    logic                  r_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data_in,
        output w_en,
        output r_en,
        output err_clr,
        input  data_out,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  data_in,
        input  w_en,
        input  r_en,
        input  err_clr,
        output data_out,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/sync_fifo_ctrl_dp_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are intentionally not reset; the controller's pointers define validity.
module fifo_dp_ram
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = clog2_f(DEFAULT_FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word on the rising edge when the controller accepts a write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary wrap-bit pointers, occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow, and either a
// registered read port (FWFT=0) or a first-word-fall-through port (FWFT=1).
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic             clk_master,
    input  logic             reset_n,
    sync_fifo_ctrl_if.slave  bus
);

    localparam int ADDR_WIDTH = clog2_f(FIFO_DEPTH);
    localparam int PTR_WIDTH  = ptr_width_f(FIFO_DEPTH);

    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] AF_LIMIT = PTR_WIDTH'(AF_THRESH);
    localparam logic [PTR_WIDTH-1:0] AE_LIMIT = PTR_WIDTH'(AE_THRESH);

    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  underflow_q;
    logic                  underflow_d;

    logic [PTR_WIDTH-1:0]  count_w;
    logic                  full_w;
    logic                  empty_w;
    logic                  w_acc;
    logic                  r_acc;
    access_e               access;
    logic [DATA_WIDTH-1:0] rd_data;

    // Status is decoded purely from the registered pointers, so it always reflects
    // the state at the start of the cycle and moves one edge after an access.
    assign count_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[PTR_WIDTH-1] != rd_ptr_q[PTR_WIDTH-1]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    // A request is only honoured when the start-of-cycle flags allow it.
    assign w_acc  = bus.w_en && !full_w;
    assign r_acc  = bus.r_en && !empty_w;
    assign access = access_e'({w_acc, r_acc});

    // Work out the next pointers, output register and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        case (access)
            ACC_WRITE: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            ACC_READ: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = rd_data;
            end
            ACC_BOTH: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = rd_data;
            end
            default: begin
            end
        endcase

        // Clear first so a fresh error in the same cycle still latches.
        if (bus.err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.w_en && full_w) begin
            overflow_d = 1'b1;
        end
        if (bus.r_en && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    // Controller state; an asynchronous reset drops all stored words at once.
    always_ff @(posedge clk_master or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk_master),
        .wr_en   (w_acc),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    // In FWFT mode the head word is shown directly; otherwise the read register is used.
    assign bus.data_out     = (FWFT != 0) ? rd_data : dout_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = count_w;
    assign bus.almost_full  = (count_w >= AF_LIMIT);
    assign bus.almost_empty = (count_w <= AE_LIMIT);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a standard-mode and an FWFT-mode instance see the same
// stimulus; a queue-based reference model predicts every cycle and a monitor compares.
module tb_sync_fifo_ctrl;
    import sync_fifo_ctrl_pkg::*;

    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    typedef struct {
        int         count;
        bit         full;
        bit         empty;
        bit         af;
        bit         ae;
        bit         ovf;
        bit         unf;
        logic [7:0] dout_std;
        bit         head_valid;
        logic [7:0] head;
    } exp_t;

    logic clk_master = 1'b0;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_unf;
    logic [7:0] m_dout;

    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_std ();
    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_fwft ();

    sync_fifo_ctrl #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (DEPTH),
        .FWFT       (0),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) u_dut_std (
        .clk_master (clk_master),
        .reset_n    (reset_n),
        .bus        (bus_std.slave)
    );

    sync_fifo_ctrl #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (DEPTH),
        .FWFT       (1),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) u_dut_fwft (
        .clk_master (clk_master),
        .reset_n    (reset_n),
        .bus        (bus_fwft.slave)
    );

    // Free-running master clock.
    always #5 clk_master = ~clk_master;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_inputs(input bit w, input bit r, input logic [7:0] d, input bit clr);
        bus_std.w_en     = w;
        bus_std.r_en     = r;
        bus_std.data_in  = d;
        bus_std.err_clr  = clr;
        bus_fwft.w_en    = w;
        bus_fwft.r_en    = r;
        bus_fwft.data_in = d;
        bus_fwft.err_clr = clr;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = 8'h00;
    endtask

    // Reference behaviour for one clock edge, then queue the predicted outputs.
    task automatic model_step(input bit w, input bit r, input logic [7:0] d, input bit clr);
        bit   was_full;
        bit   was_empty;
        exp_t e;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (w && was_full)  m_ovf = 1'b1;
        if (r && was_empty) m_unf = 1'b1;
        if (r && !was_empty) m_dout = mq.pop_front();
        if (w && !was_full)  mq.push_back(d);
        e.count      = mq.size();
        e.full       = (mq.size() == DEPTH);
        e.empty      = (mq.size() == 0);
        e.af         = (mq.size() >= AF);
        e.ae         = (mq.size() <= AE);
        e.ovf        = m_ovf;
        e.unf        = m_unf;
        e.dout_std   = m_dout;
        e.head_valid = (mq.size() != 0);
        e.head       = (mq.size() != 0) ? mq[0] : 8'h00;
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus, launched on the falling edge.
    task automatic apply_stimulus(input bit w, input bit r, input logic [7:0] d, input bit clr);
        @(negedge clk_master);
        set_inputs(w, r, d, clr);
        model_step(w, r, d, clr);
    endtask

    task automatic check_output(input exp_t e);
        cmp("std_count",      bus_std.count,        e.count);
        cmp("std_full",       bus_std.full,         e.full);
        cmp("std_empty",      bus_std.empty,        e.empty);
        cmp("std_afull",      bus_std.almost_full,  e.af);
        cmp("std_aempty",     bus_std.almost_empty, e.ae);
        cmp("std_overflow",   bus_std.overflow,     e.ovf);
        cmp("std_underflow",  bus_std.underflow,    e.unf);
        cmp("std_data_out",   bus_std.data_out,     e.dout_std);
        cmp("fwft_count",     bus_fwft.count,       e.count);
        cmp("fwft_empty",     bus_fwft.empty,       e.empty);
        cmp("fwft_full",      bus_fwft.full,        e.full);
        cmp("fwft_overflow",  bus_fwft.overflow,    e.ovf);
        cmp("fwft_underflow", bus_fwft.underflow,   e.unf);
        if (e.head_valid) begin
            cmp("fwft_data_out", bus_fwft.data_out, e.head);
        end
    endtask

    task automatic check_reset_now(input string tag);
        cmp({tag, "_std_empty"},   bus_std.empty,        1);
        cmp({tag, "_std_full"},    bus_std.full,         0);
        cmp({tag, "_std_count"},   bus_std.count,        0);
        cmp({tag, "_std_aempty"},  bus_std.almost_empty, 1);
        cmp({tag, "_std_afull"},   bus_std.almost_full,  0);
        cmp({tag, "_std_ovf"},     bus_std.overflow,     0);
        cmp({tag, "_std_unf"},     bus_std.underflow,    0);
        cmp({tag, "_std_dout"},    bus_std.data_out,     0);
        cmp({tag, "_fwft_empty"},  bus_fwft.empty,       1);
        cmp({tag, "_fwft_count"},  bus_fwft.count,       0);
    endtask

    // Monitor: just after each rising edge, compare the DUTs with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_master);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    // Directed scenarios followed by a randomised soak.
    initial begin
        int wp;
        int rp;
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        model_reset();
        reset_n = 1'b0;
        #12;
        check_reset_now("por");
        @(negedge clk_master);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b0, 8'(i), 1'b0);
        apply_stimulus(1'b1, 1'b0, 8'hEE, 1'b0);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b1, 8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);

        apply_stimulus(1'b1, 1'b0, 8'hA5, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
        @(negedge clk_master);
        #2;
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_now("midrst");
        @(negedge clk_master);
        reset_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 8'h3C, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);

        for (int phase = 0; phase < 6; phase++) begin
            wp = (phase % 2 == 0) ? 80 : 25;
            rp = (phase % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 60; i++) begin
                apply_stimulus($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                               8'($urandom), $urandom_range(0, 15) == 0);
            end
        end

        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk_master);
        #3;
        if (exp_q.size() != 0) begin
            cmp("scoreboard_drained", exp_q.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
